// File: rtl/regfile_port_sched.sv
// Single-port register-bank scheduler: serializes operand-fetch reads (rs, rt) and
// writeback writes (rd) onto one bank port, round-robin on contention, r0 hard zero.
module regfile_port_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_rs,
    input  logic [ADDR_W-1:0] rd_rt,
    output logic              rd_ack,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_rd,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_RD_DONE,
        S_WR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              last_wr_q, last_wr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rs_q      <= '0;
            rt_q      <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        last_wr_d = last_wr_q;
        rd_ack    = 1'b0;
        wr_ack    = 1'b0;
        rf_addr   = '0;
        rf_we     = 1'b0;
        rf_wdata  = '0;

        unique case (state_q)
            S_IDLE: begin
                // Read wins if it is alone or if the previous grant went to write.
                if (rd_req && (!wr_req || last_wr_q)) begin
                    rs_d    = rd_rs;
                    rt_d    = rd_rt;
                    state_d = S_RD_A;
                end else if (wr_req) begin
                    wa_d    = wr_rd;
                    wd_d    = wr_data;
                    state_d = S_WR;
                end
            end
            S_RD_A: begin
                rf_addr = rs_q;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                rf_addr = rt_q;
                op_a_d  = (rs_q == '0) ? '0 : rf_rdata;
                state_d = S_RD_DONE;
            end
            S_RD_DONE: begin
                op_b_d    = (rt_q == '0) ? '0 : rf_rdata;
                rd_ack    = 1'b1;
                last_wr_d = 1'b0;
                state_d   = S_IDLE;
            end
            S_WR: begin
                rf_addr   = wa_q;
                rf_wdata  = wd_q;
                rf_we     = (wa_q != '0);
                wr_ack    = 1'b1;
                last_wr_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy = (state_q != S_IDLE);
        op_a = op_a_q;
        // op_b passes through in RD_DONE so the new value is visible with rd_ack.
        op_b = op_b_d;

        // Reset masks the port immediately so an interrupted transaction never acks or writes.
        if (rst) begin
            rd_ack   = 1'b0;
            wr_ack   = 1'b0;
            rf_addr  = '0;
            rf_we    = 1'b0;
            rf_wdata = '0;
            busy     = 1'b0;
            op_a     = '0;
            op_b     = '0;
        end
    end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a registered-read 32x32 bank model.
module tb_regfile_port_sched;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [4:0]  rd_rs;
    logic [4:0]  rd_rt;
    logic        rd_ack;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wr_req;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] bank [32];

    regfile_port_sched #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_rs    (rd_rs),
        .rd_rt    (rd_rt),
        .rd_ack   (rd_ack),
        .op_a     (op_a),
        .op_b     (op_b),
        .wr_req   (wr_req),
        .wr_rd    (wr_rd),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rf_addr  (rf_addr),
        .rf_we    (rf_we),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) bank[rf_addr] <= rf_wdata;
        rf_rdata <= bank[rf_addr];
    end

    task automatic test_reset();
        rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        rd_rs = 5'd5; rd_rt = 5'd9; wr_rd = 5'd7; wr_data = 32'hFFFF_0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_ack, wr_ack, rf_we, busy} !== 4'b0 || rf_addr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b/%b we=%b busy=%b addr=%0d wdata=%h, required all zero",
                     rd_ack, wr_ack, rf_we, busy, rf_addr, rf_wdata);
        end
        n_checks++;
        if (op_a !== 32'd0 || op_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ops: op_a=%h op_b=%h, required 0/0", op_a, op_b);
        end
        rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rd_ack !== 1'b0 || wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b rd_ack=%b wr_ack=%b, required 0", busy, rd_ack, wr_ack);
        end
    endtask

    task automatic test_read();
        rd_req = 1'b1; rd_rs = 5'd5; rd_rt = 5'd9;
        @(negedge clk);
        n_checks++;
        if (rf_addr !== 5'd5 || busy !== 1'b1 || rd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rd_a: addr=%0d busy=%b ack=%b, required 5/1/0", rf_addr, busy, rd_ack);
        end
        @(negedge clk);
        n_checks++;
        if (rf_addr !== 5'd9 || rd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rd_b: addr=%0d ack=%b, required 9/0", rf_addr, rd_ack);
        end
        @(negedge clk);
        n_checks++;
        if (rd_ack !== 1'b1 || rf_addr !== 5'd0 || op_a !== 32'hDEAD_BEEF || op_b !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_done: ack=%b addr=%0d op_a=%h op_b=%h, required 1/0/deadbeef/12345678",
                     rd_ack, rf_addr, op_a, op_b);
        end
        rd_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_ack !== 1'b0 || busy !== 1'b0 || op_a !== 32'hDEAD_BEEF || op_b !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_hold: ack=%b busy=%b op_a=%h op_b=%h, required 0/0/deadbeef/12345678",
                     rd_ack, busy, op_a, op_b);
        end
    endtask

    task automatic test_write_then_read();
        wr_req = 1'b1; wr_rd = 5'd7; wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        n_checks++;
        if (wr_ack !== 1'b1 || rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_wdata !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL write_cycle: ack=%b we=%b addr=%0d wdata=%h, required 1/1/7/a5a5a5a5",
                     wr_ack, rf_we, rf_addr, rf_wdata);
        end
        wr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_ack !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_after: ack=%b we=%b busy=%b, required 0/0/0", wr_ack, rf_we, busy);
        end
        rd_req = 1'b1; rd_rs = 5'd7; rd_rt = 5'd7;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_ack !== 1'b1 || op_a !== 32'hA5A5_A5A5 || op_b !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL raw_same_index: ack=%b op_a=%h op_b=%h, required 1/a5a5a5a5/a5a5a5a5",
                     rd_ack, op_a, op_b);
        end
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_r0();
        wr_req = 1'b1; wr_rd = 5'd0; wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++;
        if (wr_ack !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_write: ack=%b we=%b, required 1/0", wr_ack, rf_we);
        end
        wr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bank[0] !== 32'hBAD0_BAD0) begin
            n_fail++;
            $display("FAIL r0_bank: bank0=%h, required bad0bad0", bank[0]);
        end
        rd_req = 1'b1; rd_rs = 5'd0; rd_rt = 5'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_ack !== 1'b1 || op_a !== 32'd0 || op_b !== 32'd0) begin
            n_fail++;
            $display("FAIL r0_read: ack=%b op_a=%h op_b=%h, required 1/0/0", rd_ack, op_a, op_b);
        end
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int unsigned exp_cyc [8] = '{1, 5, 7, 11, 13, 17, 19, 23};
        int unsigned idx = 0;
        logic        overlap = 1'b0;
        logic [31:0] last_wd = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        rd_rs = 5'd3; rd_rt = 5'd3; wr_rd = 5'd3; wr_data = 32'h1000_0000;
        for (int unsigned c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rd_ack && wr_ack) overlap = 1'b1;
            if (wr_ack) begin
                n_checks++;
                if (idx >= 8 || c != exp_cyc[idx] || idx[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL arb_wr_grant: wr_ack at cycle %0d as ack #%0d, required even ack # at its table cycle", c, idx);
                end
                last_wd = wr_data;
                wr_data = wr_data + 32'd1;
                idx++;
                if (c >= 18) wr_req = 1'b0;
            end
            if (rd_ack) begin
                n_checks++;
                if (idx >= 8 || c != exp_cyc[idx] || idx[0] !== 1'b1 || op_a !== last_wd || op_b !== last_wd) begin
                    n_fail++;
                    $display("FAIL arb_rd_grant: rd_ack at cycle %0d as ack #%0d op_a=%h op_b=%h, required odd ack # at table cycle and %h",
                             c, idx, op_a, op_b, last_wd);
                end
                idx++;
                if (c >= 18) rd_req = 1'b0;
            end
            if (!rd_req && !wr_req && !busy) break;
        end
        n_checks++;
        if (idx != 8 || overlap) begin
            n_fail++;
            $display("FAIL arb_summary: acks=%0d overlap=%b, required 8/0", idx, overlap);
        end
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic seen = 1'b0;
        rd_req = 1'b1; rd_rs = 5'd5; rd_rt = 5'd9;
        repeat (2) @(negedge clk);
        rst = 1'b1; rd_req = 1'b0;
        #1;
        n_checks++;
        if (rd_ack !== 1'b0 || busy !== 1'b0 || rf_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_rd_b: ack=%b busy=%b addr=%0d, required 0/0/0", rd_ack, busy, rf_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || op_a !== 32'd0 || op_b !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_rd_after: busy=%b op_a=%h op_b=%h, required 0/0/0", busy, op_a, op_b);
        end
        repeat (5) begin
            @(negedge clk);
            if (rd_ack || wr_ack || rf_we) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rd_noack: ack or we seen=%b, required 0", seen);
        end
    endtask

    task automatic test_reset_mid_write();
        logic seen = 1'b0;
        wr_req = 1'b1; wr_rd = 5'd12; wr_data = 32'h0000_0055;
        @(negedge clk);
        rst = 1'b1; wr_req = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || wr_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wr: we=%b ack=%b busy=%b, required 0/0/0", rf_we, wr_ack, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rd_ack || wr_ack || rf_we || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || bank[12] !== 32'h5000_000C) begin
            n_fail++;
            $display("FAIL rst_wr_after: activity=%b bank12=%h, required 0/5000000c", seen, bank[12]);
        end
    endtask

    task automatic test_index_stability();
        rd_req = 1'b1; rd_rs = 5'd5; rd_rt = 5'd9;
        @(negedge clk);
        rd_rs = 5'd7;  rd_rt = 5'd3;
        @(negedge clk);
        rd_rs = 5'd0;  rd_rt = 5'd0;
        @(negedge clk);
        rd_rs = 5'd12; rd_rt = 5'd7;
        #1;
        n_checks++;
        if (rd_ack !== 1'b1 || op_a !== 32'hDEAD_BEEF || op_b !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL index_stability: ack=%b op_a=%h op_b=%h, required 1/deadbeef/12345678",
                     rd_ack, op_a, op_b);
        end
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'h5000_0000 + 32'(i);
        bank[0] = 32'hBAD0_BAD0;
        bank[5] = 32'hDEAD_BEEF;
        bank[9] = 32'h1234_5678;
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_rs = '0; rd_rt = '0; wr_rd = '0; wr_data = '0;

        test_reset();
        test_read();
        test_write_then_read();
        test_r0();
        test_back_to_back();
        test_reset_mid_read();
        test_reset_mid_write();
        test_index_stability();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
